// File: rtl/skin_bbox_detect.sv
// Skin-tone classifier with per-frame bounding-box accumulation and a luma overlay
// that draws the previous frame's box. Video passes through a 2-clock pipeline.
module skin_bbox_detect #(
    parameter int H_ACT   = 640,
    parameter int V_ACT   = 480,
    parameter int CB_MIN  = 77,
    parameter int CB_MAX  = 127,
    parameter int CR_MIN  = 133,
    parameter int CR_MAX  = 173,
    parameter int MIN_PIX = 64,
    parameter int BOX_Y   = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pre_frame_vsync,
    input  logic        pre_frame_hsync,
    input  logic        pre_frame_de,
    input  logic [7:0]  img_y,
    input  logic [7:0]  img_cb,
    input  logic [7:0]  img_cr,
    output logic        post_frame_vsync,
    output logic        post_frame_hsync,
    output logic        post_frame_de,
    output logic [7:0]  post_img_y,
    output logic        skin_mask,
    output logic        box_valid,
    output logic [10:0] box_x_min,
    output logic [10:0] box_x_max,
    output logic [10:0] box_y_min,
    output logic [10:0] box_y_max,
    output logic [19:0] skin_cnt,
    output logic        frame_done
);

    localparam logic [10:0] CMAX    = 11'd2047;
    localparam logic [10:0] H_LIM   = 11'(H_ACT);
    localparam logic [10:0] V_LIM   = 11'(V_ACT);
    localparam logic [7:0]  CB_LO   = 8'(CB_MIN);
    localparam logic [7:0]  CB_HI   = 8'(CB_MAX);
    localparam logic [7:0]  CR_LO   = 8'(CR_MIN);
    localparam logic [7:0]  CR_HI   = 8'(CR_MAX);
    localparam logic [19:0] MIN_CNT = 20'(MIN_PIX);
    localparam logic [7:0]  BOX_VAL = 8'(BOX_Y);

    typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, LATCH = 2'd2} state_t;

    function automatic logic [10:0] sat_inc11(input logic [10:0] v);
        return (v == CMAX) ? v : v + 11'd1;
    endfunction

    function automatic logic [19:0] sat_inc20(input logic [19:0] v);
        return (&v) ? v : v + 20'd1;
    endfunction

    state_t      state;
    logic        vs_d, de_d;
    logic [10:0] x_cnt, y_cnt;
    logic        vs_rise, de_fall, skin, on_col, on_row, border, accum_en;
    logic [10:0] acc_xmin, acc_xmax, acc_ymin, acc_ymax;
    logic [19:0] acc_cnt;
    logic [10:0] base_xmin, base_xmax, base_ymin, base_ymax;
    logic [19:0] base_cnt;
    logic [10:0] nxt_xmin, nxt_xmax, nxt_ymin, nxt_ymax;
    logic [19:0] nxt_cnt;
    logic        vs_p0, hs_p0, de_p0, skin_p0, border_p0;
    logic [7:0]  y_p0;

    assign vs_rise = pre_frame_vsync & ~vs_d;
    assign de_fall = de_d & ~pre_frame_de;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_d  <= 1'b0;
            de_d  <= 1'b0;
            x_cnt <= '0;
            y_cnt <= '0;
        end else begin
            vs_d <= pre_frame_vsync;
            de_d <= pre_frame_de;
            if (pre_frame_de)
                x_cnt <= sat_inc11(x_cnt);
            else if (de_fall)
                x_cnt <= '0;
            if (vs_rise)
                y_cnt <= '0;
            else if (de_fall)
                y_cnt <= sat_inc11(y_cnt);
        end
    end

    assign skin = pre_frame_de & (x_cnt < H_LIM) & (y_cnt < V_LIM)
                & (img_cb > CB_LO) & (img_cb < CB_HI)
                & (img_cr > CR_LO) & (img_cr < CR_HI);

    assign on_col = ((x_cnt == box_x_min) | (x_cnt == box_x_max))
                  & (y_cnt >= box_y_min) & (y_cnt <= box_y_max);
    assign on_row = ((y_cnt == box_y_min) | (y_cnt == box_y_max))
                  & (x_cnt >= box_x_min) & (x_cnt <= box_x_max);
    assign border = box_valid & (state != IDLE) & pre_frame_de & (on_col | on_row);

    // A vsync edge owns its cycle: the coincident pixel belongs to neither frame.
    assign accum_en = skin & ~vs_rise & (state != IDLE);

    // In LATCH the accumulators restart, so a pixel there seeds the new frame.
    always_comb begin
        base_xmin = acc_xmin;
        base_xmax = acc_xmax;
        base_ymin = acc_ymin;
        base_ymax = acc_ymax;
        base_cnt  = acc_cnt;
        if (state == LATCH) begin
            base_xmin = CMAX;
            base_xmax = '0;
            base_ymin = CMAX;
            base_ymax = '0;
            base_cnt  = '0;
        end
        nxt_xmin = base_xmin;
        nxt_xmax = base_xmax;
        nxt_ymin = base_ymin;
        nxt_ymax = base_ymax;
        nxt_cnt  = base_cnt;
        if (accum_en) begin
            if (x_cnt < base_xmin) nxt_xmin = x_cnt;
            if (x_cnt > base_xmax) nxt_xmax = x_cnt;
            if (y_cnt < base_ymin) nxt_ymin = y_cnt;
            if (y_cnt > base_ymax) nxt_ymax = y_cnt;
            nxt_cnt = sat_inc20(base_cnt);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            acc_xmin   <= CMAX;
            acc_xmax   <= '0;
            acc_ymin   <= CMAX;
            acc_ymax   <= '0;
            acc_cnt    <= '0;
            box_valid  <= 1'b0;
            box_x_min  <= '0;
            box_x_max  <= '0;
            box_y_min  <= '0;
            box_y_max  <= '0;
            skin_cnt   <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (vs_rise) state <= ACCUM;
                end
                ACCUM: begin
                    if (vs_rise) begin
                        state <= LATCH;
                    end else begin
                        acc_xmin <= nxt_xmin;
                        acc_xmax <= nxt_xmax;
                        acc_ymin <= nxt_ymin;
                        acc_ymax <= nxt_ymax;
                        acc_cnt  <= nxt_cnt;
                    end
                end
                LATCH: begin
                    frame_done <= 1'b1;
                    skin_cnt   <= acc_cnt;
                    if (acc_cnt >= MIN_CNT) begin
                        box_valid <= 1'b1;
                        box_x_min <= acc_xmin;
                        box_x_max <= acc_xmax;
                        box_y_min <= acc_ymin;
                        box_y_max <= acc_ymax;
                    end else begin
                        box_valid <= 1'b0;
                        box_x_min <= '0;
                        box_x_max <= '0;
                        box_y_min <= '0;
                        box_y_max <= '0;
                    end
                    acc_xmin <= nxt_xmin;
                    acc_xmax <= nxt_xmax;
                    acc_ymin <= nxt_ymin;
                    acc_ymax <= nxt_ymax;
                    acc_cnt  <= nxt_cnt;
                    state    <= ACCUM;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stage p0: classification and border decision; stage p1: overlay onto luma
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_p0            <= 1'b0;
            hs_p0            <= 1'b0;
            de_p0            <= 1'b0;
            skin_p0          <= 1'b0;
            border_p0        <= 1'b0;
            y_p0             <= '0;
            post_frame_vsync <= 1'b0;
            post_frame_hsync <= 1'b0;
            post_frame_de    <= 1'b0;
            skin_mask        <= 1'b0;
            post_img_y       <= '0;
        end else begin
            vs_p0            <= pre_frame_vsync;
            hs_p0            <= pre_frame_hsync;
            de_p0            <= pre_frame_de;
            skin_p0          <= skin;
            border_p0        <= border;
            y_p0             <= img_y;
            post_frame_vsync <= vs_p0;
            post_frame_hsync <= hs_p0;
            post_frame_de    <= de_p0;
            skin_mask        <= skin_p0;
            post_img_y       <= de_p0 ? (border_p0 ? BOX_VAL : y_p0) : 8'd0;
        end
    end

endmodule

// File: tb/tb_skin_bbox_detect.sv
// Directed bench for skin_bbox_detect: per-cycle video expectations and box
// expectations are queued when driven and checked when they fall due.
module tb_skin_bbox_detect;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pre_frame_vsync = 1'b0, pre_frame_hsync = 1'b0, pre_frame_de = 1'b0;
    logic [7:0]  img_y = '0, img_cb = '0, img_cr = '0;
    logic        post_frame_vsync, post_frame_hsync, post_frame_de, skin_mask;
    logic [7:0]  post_img_y;
    logic        box_valid, frame_done;
    logic [10:0] box_x_min, box_x_max, box_y_min, box_y_max;
    logic [19:0] skin_cnt;

    always #5 clk = ~clk;

    skin_bbox_detect dut (
        .clk(clk), .rst_n(rst_n),
        .pre_frame_vsync(pre_frame_vsync), .pre_frame_hsync(pre_frame_hsync),
        .pre_frame_de(pre_frame_de), .img_y(img_y), .img_cb(img_cb), .img_cr(img_cr),
        .post_frame_vsync(post_frame_vsync), .post_frame_hsync(post_frame_hsync),
        .post_frame_de(post_frame_de), .post_img_y(post_img_y), .skin_mask(skin_mask),
        .box_valid(box_valid), .box_x_min(box_x_min), .box_x_max(box_x_max),
        .box_y_min(box_y_min), .box_y_max(box_y_max), .skin_cnt(skin_cnt),
        .frame_done(frame_done)
    );

    typedef struct packed {
        logic        v;
        logic [10:0] x0, x1, y0, y1;
        logic [19:0] c;
    } box_t;
    typedef struct { int due; logic [11:0] val; } pix_e;
    typedef struct { int due; box_t b; } box_e;

    pix_e pixq[$];
    box_e boxq[$];
    int   cyc = 0, nvec = 0, nbad = 0;
    box_t cur = '0, arm = '0, nb = '0;
    bit   armed = 0;
    logic prev_vs = 1'b0;
    logic r_in = 1'b0, vs_in = 1'b0, hs_in = 1'b0, de_in = 1'b0;
    logic [7:0] y_in = '0, cb_in = '0, cr_in = '0;
    int   px = 0, py = 0;
    logic [7:0] bcb [5] = '{8'd77, 8'd127, 8'd100, 8'd100, 8'd78};
    logic [7:0] bcr [5] = '{8'd150, 8'd150, 8'd133, 8'd173, 8'd134};

    function automatic box_t mkbox(input logic v, input int x0, x1, y0, y1, c);
        box_t b;
        b.v = v; b.x0 = 11'(x0); b.x1 = 11'(x1); b.y0 = 11'(y0); b.y1 = 11'(y1); b.c = 20'(c);
        return b;
    endfunction

    function automatic logic win(input logic [7:0] cb, input logic [7:0] cr);
        return (cb > 8'd77) && (cb < 8'd127) && (cr > 8'd133) && (cr < 8'd173);
    endfunction

    function automatic logic on_border(input int x, input int y, input box_t b);
        int x0, x1, y0, y1;
        x0 = int'(b.x0); x1 = int'(b.x1); y0 = int'(b.y0); y1 = int'(b.y1);
        return ((x == x0 || x == x1) && y >= y0 && y <= y1) ||
               ((y == y0 || y == y1) && x >= x0 && x <= x1);
    endfunction

    task automatic tick();
        pix_e p;
        box_e q;
        logic fd, m;
        logic [7:0] yy;
        logic [11:0] e;
        @(negedge clk);
        if (pixq.size() > 0 && pixq[0].due == cyc) begin
            p = pixq.pop_front();
            nvec++;
            assert ({post_frame_vsync, post_frame_hsync, post_frame_de, skin_mask, post_img_y} === p.val)
            else begin
                nbad++;
                $error("FAIL video t=%0d observed=%h expected=%h", cyc,
                       {post_frame_vsync, post_frame_hsync, post_frame_de, skin_mask, post_img_y}, p.val);
            end
        end
        fd = 1'b0;
        if (boxq.size() > 0 && boxq[0].due == cyc) begin
            q = boxq.pop_front();
            cur = q.b;
            fd = 1'b1;
        end
        nvec++;
        assert ({frame_done, box_valid, box_x_min, box_x_max, box_y_min, box_y_max, skin_cnt} === {fd, cur})
        else begin
            nbad++;
            $error("FAIL box t=%0d observed=%h expected=%h", cyc,
                   {frame_done, box_valid, box_x_min, box_x_max, box_y_min, box_y_max, skin_cnt}, {fd, cur});
        end
        if (!r_in && rst_n) begin
            pixq.delete();
            boxq.delete();
            armed = 0;
            cur = '0;
        end
        rst_n = r_in; pre_frame_vsync = vs_in; pre_frame_hsync = hs_in; pre_frame_de = de_in;
        img_y = y_in; img_cb = cb_in; img_cr = cr_in;
        if (r_in && vs_in && !prev_vs) begin
            if (armed) boxq.push_back('{cyc + 2, arm});
            arm = nb;
            armed = 1;
        end
        prev_vs = r_in ? vs_in : 1'b0;
        m  = de_in && px < 640 && py < 480 && win(cb_in, cr_in);
        yy = !de_in ? 8'd0 : ((cur.v && on_border(px, py, cur)) ? 8'd255 : y_in);
        e  = r_in ? {vs_in, hs_in, de_in, m, yy} : 12'd0;
        pixq.push_back('{cyc + 2, e});
        cyc++;
    endtask

    task automatic line(input int l, input int n, input int bx, input int by, input int bs, input int mode);
        de_in = 0; vs_in = 0; hs_in = 1;
        tick(); tick();
        hs_in = 0;
        tick();
        for (int x = 0; x < n; x++) begin
            de_in = 1; px = x; py = l;
            cb_in = 8'd128; cr_in = 8'd128;
            y_in = 8'((x * 3 + l * 7) % 200);
            if (x >= bx && x < bx + bs && l >= by && l < by + bs) begin
                cb_in = 8'd100; cr_in = 8'd150;
            end
            if (mode == 1 && l == 0 && x < 5) begin
                cb_in = bcb[x]; cr_in = bcr[x];
            end
            if (mode == 1 && l == 1 && x == 650) begin
                cb_in = 8'd100; cr_in = 8'd150;
            end
            tick();
        end
        de_in = 0;
        tick();
    endtask

    task automatic vs_start(input box_t exp);
        nb = exp; vs_in = 1; hs_in = 0; de_in = 0;
        repeat (3) tick();
        vs_in = 0;
        repeat (2) tick();
    endtask

    task automatic frame(input int nl, input int np, input int bx, input int by, input int bs,
                         input int mode, input box_t exp);
        vs_start(exp);
        for (int l = 0; l < nl; l++)
            line(l, (mode == 1 && l == 1) ? 700 : np, bx, by, bs, mode);
    endtask

    initial begin
        r_in = 0;
        repeat (3) tick();
        r_in = 1;
        tick();
        // partial frame interrupted by reset mid-line
        vs_start('0);
        for (int l = 0; l < 56; l++) line(l, 120, 100, 50, 16, 0);
        for (int x = 0; x < 10; x++) begin
            de_in = 1; px = x; py = 56; cb_in = 8'd100; cr_in = 8'd150; y_in = 8'(x + 20);
            tick();
        end
        r_in = 0; de_in = 0; vs_in = 0; hs_in = 0; cb_in = 0; cr_in = 0; y_in = 0;
        repeat (4) tick();
        r_in = 1;
        repeat (3) tick();
        // 16x16 block, then 7x7 block (overlay of the 16x16 box), boundaries, empty frame
        frame(68, 120, 100, 50, 16, 0, mkbox(1'b1, 100, 115, 50, 65, 256));
        frame(68, 120, 10, 5, 7, 0, mkbox(1'b0, 0, 0, 0, 0, 49));
        frame(2, 120, 0, 0, 0, 1, mkbox(1'b0, 0, 0, 0, 0, 1));
        frame(3, 20, 0, 0, 0, 0, mkbox(1'b0, 0, 0, 0, 0, 0));
        // vsync edge coincident with a skin pixel: shown, never accumulated
        nb = '0; vs_in = 1; hs_in = 0; de_in = 1; px = 0; py = 3;
        cb_in = 8'd100; cr_in = 8'd150; y_in = 8'd42;
        tick();
        de_in = 0;
        repeat (2) tick();
        vs_in = 0;
        repeat (4) tick();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
